// File: rtl/conv_pool_chan_seq.sv
// Multi-channel KxK convolution over an IMGxIMG tile, one output position per cycle,
// accumulated across NUM_CH channel beats, with optional ReLU and 2x2 max-pool.
module conv_pool_chan_seq #(
    parameter int IMG_DIM = 4,
    parameter int K_DIM   = 3,
    parameter int NUM_CH  = 1,
    parameter int ACC_W   = 24,
    parameter int POOL_EN = 0,
    localparam int OUT_DIM = IMG_DIM - K_DIM + 1,
    localparam int PO      = (POOL_EN != 0) ? OUT_DIM / 2 : OUT_DIM
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IMG_DIM*IMG_DIM*8-1:0] image,
    input  logic [K_DIM*K_DIM*8-1:0]     kernel,
    input  logic                         relu_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PO*PO*ACC_W-1:0]       out_data
);
    localparam int NPOS  = OUT_DIM * OUT_DIM;
    localparam int POS_W = (NPOS > 1) ? $clog2(NPOS) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (OUT_DIM < 1) begin : g_bad_dim
        $error("conv_pool_chan_seq: K_DIM must not exceed IMG_DIM");
    end
    if (POOL_EN != 0 && (OUT_DIM % 2) != 0) begin : g_bad_pool
        $error("conv_pool_chan_seq: 2x2 pooling needs an even OUT_DIM");
    end
    if (NUM_CH < 1) begin : g_bad_ch
        $error("conv_pool_chan_seq: NUM_CH must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

    state_t                      state;
    logic [POS_W-1:0]            pos;
    logic [CH_W-1:0]             ch_cnt;
    logic                        relu_q;
    logic [IMG_DIM*IMG_DIM*8-1:0] img_p0;
    logic [K_DIM*K_DIM*8-1:0]     ker_p0;
    logic signed [ACC_W-1:0]     acc [NPOS];
    logic signed [ACC_W-1:0]     dot_p0;

    // Unsigned pixel (zero-extended to 9b) times signed weight; fits exactly in 17b.
    function automatic logic signed [16:0] mul_px(input logic [7:0] px, input logic [7:0] w);
        logic signed [16:0] a, b;
        a = 17'($signed({1'b0, px}));
        b = 17'($signed(w));
        return a * b;
    endfunction

    function automatic logic signed [ACC_W-1:0] widen(input logic signed [16:0] p);
        return ACC_W'(p);
    endfunction

    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] x,
                                                     input logic en);
        return (en && x < 0) ? '0 : x;
    endfunction

    function automatic logic signed [ACC_W-1:0] smax(input logic signed [ACC_W-1:0] a,
                                                     input logic signed [ACC_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign in_ready = rst && (state == IDLE);

    // Stage p0: dot product of the latched tile window at the current position
    always_comb begin
        int pr, pc;
        pr     = int'(pos) / OUT_DIM;
        pc     = int'(pos) % OUT_DIM;
        dot_p0 = '0;
        for (int i = 0; i < K_DIM; i++) begin
            for (int j = 0; j < K_DIM; j++) begin
                dot_p0 = dot_p0 + widen(mul_px(img_p0[((pr + i) * IMG_DIM + pc + j) * 8 +: 8],
                                               ker_p0[(i * K_DIM + j) * 8 +: 8]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pos       <= '0;
            ch_cnt    <= '0;
            relu_q    <= 1'b0;
            out_valid <= 1'b0;
            for (int p = 0; p < NPOS; p++) acc[p] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        img_p0 <= image;
                        ker_p0 <= kernel;
                        pos    <= '0;
                        if (ch_cnt == '0) relu_q <= relu_en;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    // First channel of a frame overwrites instead of accumulating
                    acc[pos] <= ((ch_cnt == '0) ? {ACC_W{1'b0}} : acc[pos]) + dot_p0;
                    if (pos == POS_W'(NPOS - 1)) begin
                        pos <= '0;
                        if (ch_cnt == CH_W'(NUM_CH - 1)) begin
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            ch_cnt <= ch_cnt + 1'b1;
                            state  <= IDLE;
                        end
                    end else begin
                        pos <= pos + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ch_cnt    <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if (POOL_EN != 0) begin : g_pool
        always_comb begin
            logic signed [ACC_W-1:0] m;
            int b;
            out_data = '0;
            for (int r = 0; r < PO; r++) begin
                for (int c = 0; c < PO; c++) begin
                    b = 2 * r * OUT_DIM + 2 * c;
                    m = smax(smax(relu(acc[b], relu_q), relu(acc[b + 1], relu_q)),
                             smax(relu(acc[b + OUT_DIM], relu_q), relu(acc[b + OUT_DIM + 1], relu_q)));
                    out_data[(r * PO + c) * ACC_W +: ACC_W] = m;
                end
            end
        end
    end else begin : g_raw
        always_comb begin
            out_data = '0;
            for (int p = 0; p < NPOS; p++) begin
                out_data[p * ACC_W +: ACC_W] = relu(acc[p], relu_q);
            end
        end
    end
endmodule

// File: tb/tb_conv_pool_chan_seq.sv
// Bench for conv_pool_chan_seq: four instances (default, pooled, 3-channel, 2-channel)
// checked against an integer-arithmetic convolution model.
`timescale 1ns/1ps
module tb_conv_pool_chan_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] image;
    logic [71:0]  kernel;
    logic         relu_en;
    logic [3:0]   in_valid, out_ready;
    wire  [3:0]   in_ready, out_valid;
    wire  [95:0]  od0, od2, od3;
    wire  [23:0]  od1;

    int tests = 0;
    int fails = 0;
    int m_acc [4];

    conv_pool_chan_seq u0 (.clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .image(image), .kernel(kernel), .relu_en(relu_en), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(od0));
    conv_pool_chan_seq #(.POOL_EN(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .image(image), .kernel(kernel), .relu_en(relu_en),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1));
    conv_pool_chan_seq #(.NUM_CH(3)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .image(image), .kernel(kernel), .relu_en(relu_en),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2));
    conv_pool_chan_seq #(.NUM_CH(2)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .image(image), .kernel(kernel), .relu_en(relu_en),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(od3));

    function automatic logic [95:0] od(input int k);
        case (k)
            0:       return od0;
            1:       return {72'b0, od1};
            2:       return od2;
            default: return od3;
        endcase
    endfunction

    function automatic int el(input int k, input int idx);
        logic [95:0] v;
        v = od(k);
        return int'($signed(v[idx*24 +: 24]));
    endfunction

    function automatic logic [127:0] rnd_img();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [71:0] rnd_ker();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[71:0];
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 4; p++) m_acc[p] = 0;
    endtask

    // 2x2 valid-convolution of a 4x4 tile with a 3x3 kernel, added into the model accumulators
    task automatic model_add(input logic [127:0] img, input logic [71:0] ker);
        int s;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += int'(img[((r + i) * 4 + c + j) * 8 +: 8]) *
                             int'($signed(ker[(i * 3 + j) * 8 +: 8]));
                m_acc[r * 2 + c] += s;
            end
        end
    endtask

    function automatic logic [95:0] expect_frame(input logic relu, input bit pool);
        logic signed [23:0] e [4];
        logic signed [23:0] m;
        logic [95:0] v;
        for (int p = 0; p < 4; p++) begin
            e[p] = 24'(m_acc[p]);
            if (relu && e[p] < 0) e[p] = 0;
        end
        v = '0;
        if (pool) begin
            m = e[0];
            for (int p = 1; p < 4; p++) if (e[p] > m) m = e[p];
            v[23:0] = m;
        end else begin
            for (int p = 0; p < 4; p++) v[p*24 +: 24] = e[p];
        end
        return v;
    endfunction

    // One channel beat; checks CONV busy window and the completion cycle (t+5)
    task automatic beat(input int k, input logic [127:0] img, input logic [71:0] ker,
                        input logic re, input bit last);
        int n;
        bit bad;
        image = img; kernel = ker; relu_en = re; in_valid[k] = 1'b1;
        n = 0;
        while (in_ready[k] !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (in_ready[k] !== 1'b1) begin
            fails++;
            $display("FAIL accept k=%0d in_ready=%b required 1", k, in_ready[k]);
            in_valid[k] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        image = rnd_img(); kernel = rnd_ker(); relu_en = ~re;
        bad = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL conv_busy k=%0d in_ready/out_valid nonzero during CONV, required 0", k);
        end
        tests++;
        if (last) begin
            if (out_valid[k] !== 1'b1) begin
                fails++;
                $display("FAIL latency k=%0d out_valid=%b at t+5, required 1", k, out_valid[k]);
            end
        end else if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            fails++;
            $display("FAIL chan_done k=%0d out_valid=%b in_ready=%b required 0/1",
                     k, out_valid[k], in_ready[k]);
        end
    endtask

    task automatic check_frame(input int k, input logic relu, input string name);
        logic [95:0] exp;
        exp = expect_frame(relu, k == 1);
        tests++;
        if (od(k) !== exp) begin
            fails++;
            $display("FAIL %s k=%0d out_data=%h required %h", name, k, od(k), exp);
        end
    endtask

    task automatic finish_frame(input int k);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        tests++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            fails++;
            $display("FAIL out_handshake k=%0d out_valid=%b in_ready=%b required 0/1",
                     k, out_valid[k], in_ready[k]);
        end
    endtask

    // Later beats drive the inverted relu_en to show it is only taken on the first beat
    task automatic frame_fixed(input int k, input int nch, input logic [127:0] img,
                               input logic [71:0] ker, input logic relu, input string name);
        model_clear();
        for (int ch = 0; ch < nch; ch++) begin
            model_add(img, ker);
            beat(k, img, ker, (ch == 0) ? relu : ~relu, ch == nch - 1);
        end
        check_frame(k, relu, name);
    endtask

    task automatic frame_rand(input int k, input int nch);
        logic [127:0] img;
        logic [71:0]  ker;
        logic         relu;
        relu = 1'($urandom_range(0, 1));
        model_clear();
        for (int ch = 0; ch < nch; ch++) begin
            img = rnd_img(); ker = rnd_ker();
            model_add(img, ker);
            beat(k, img, ker, (ch == 0) ? relu : 1'($urandom_range(0, 1)), ch == nch - 1);
        end
        check_frame(k, relu, "random");
        finish_frame(k);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 4'b0000 || out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl in_ready=%b out_valid=%b required 0000/0000", in_ready, out_valid);
        end
        tests++;
        if (od0 !== '0 || od1 !== '0 || od2 !== '0 || od3 !== '0) begin
            fails++;
            $display("FAIL reset_data out_data=%h %h %h %h required 0", od0, od1, od2, od3);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 4'b1111) begin
            fails++;
            $display("FAIL reset_release in_ready=%b required 1111", in_ready);
        end
    endtask

    task automatic test_centre();
        logic [127:0] img;
        for (int i = 0; i < 16; i++) img[i*8 +: 8] = 8'(i);
        frame_fixed(0, 1, img, 72'h01 << 32, 1'b0, "centre");
        tests++;
        if (el(0, 0) != 5 || el(0, 1) != 6 || el(0, 2) != 9 || el(0, 3) != 10) begin
            fails++;
            $display("FAIL centre_const got %0d %0d %0d %0d required 5 6 9 10",
                     el(0, 0), el(0, 1), el(0, 2), el(0, 3));
        end
        finish_frame(0);
    endtask

    task automatic test_all_neg();
        frame_fixed(0, 1, '1, '1, 1'b0, "all_neg");
        tests++;
        if (el(0, 0) != -2295 || el(0, 3) != -2295) begin
            fails++;
            $display("FAIL all_neg_const got %0d %0d required -2295", el(0, 0), el(0, 3));
        end
        finish_frame(0);
        frame_fixed(0, 1, '1, '1, 1'b1, "all_neg_relu");
        finish_frame(0);
    endtask

    task automatic test_pool();
        logic [127:0] img;
        for (int i = 0; i < 16; i++) img[i*8 +: 8] = 8'(i);
        frame_fixed(1, 1, img, 72'h01 << 32, 1'b0, "pool_centre");
        tests++;
        if (el(1, 0) != 10) begin
            fails++;
            $display("FAIL pool_centre_const got %0d required 10", el(1, 0));
        end
        finish_frame(1);
        frame_fixed(1, 1, '1, '1, 1'b0, "pool_neg");
        tests++;
        if (el(1, 0) != -2295) begin
            fails++;
            $display("FAIL pool_neg_const got %0d required -2295", el(1, 0));
        end
        finish_frame(1);
        frame_fixed(1, 1, '1, '1, 1'b1, "pool_neg_relu");
        finish_frame(1);
    endtask

    task automatic test_multi_ch();
        frame_fixed(2, 3, {16{8'h02}}, {9{8'h01}}, 1'b0, "multi_ch");
        tests++;
        if (el(2, 0) != 54 || el(2, 3) != 54) begin
            fails++;
            $display("FAIL multi_ch_const got %0d %0d required 54", el(2, 0), el(2, 3));
        end
        finish_frame(2);
        frame_rand(2, 3);
        frame_rand(2, 3);
    endtask

    task automatic test_back_pressure();
        logic [95:0] exp;
        bit bad;
        frame_fixed(0, 1, rnd_img(), rnd_ker(), 1'b0, "bp_frame");
        exp = expect_frame(1'b0, 1'b0);
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid[0] = c[0];
            image = rnd_img(); kernel = rnd_ker();
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || od0 !== exp) bad = 1'b1;
        end
        in_valid[0] = 1'b0;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL back_pressure out_valid=%b in_ready=%b out_data=%h required 1/0/%h",
                     out_valid[0], in_ready[0], od0, exp);
        end
        finish_frame(0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            out_ready[0] = 1'b1;
            frame_rand(0, 1);
        end
    endtask

    task automatic test_reset_abort();
        bit bad;
        model_clear();
        beat(3, '1, '1, 1'b0, 1'b0);
        image = '1; kernel = '1; relu_en = 1'b0; in_valid[3] = 1'b1;
        @(posedge clk); #1;
        in_valid[3] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (in_ready !== 4'b0000 || out_valid[3] !== 1'b0 || od3 !== '0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL abort_reset in_ready=%b out_valid=%b out_data=%h required 0/0/0",
                     in_ready, out_valid[3], od3);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        frame_fixed(3, 2, {16{8'h01}}, {9{8'h01}}, 1'b0, "after_abort");
        tests++;
        if (el(3, 0) != 18 || el(3, 3) != 18) begin
            fails++;
            $display("FAIL after_abort_const got %0d %0d required 18", el(3, 0), el(3, 3));
        end
        finish_frame(3);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 4; k++) begin
                frame_rand(k, (k == 2) ? 3 : (k == 3) ? 2 : 1);
            end
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = '0; out_ready = '0;
        image = '0; kernel = '0; relu_en = 1'b0;
        test_reset();
        test_centre();
        test_all_neg();
        test_pool();
        test_multi_ch();
        test_back_pressure();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
